ascii2bin: RTL and testbench

Sequential hex-text parser for the keyboard path: consumes ASCII characters one per handshake and assembles up to `NBYTES*2` hex digits into a binary word. On an Enter character it publishes the word through a valid/ready output port. It is the inverse of the team's binary-to-ASCII hex formatter: the formatter displays values, this block reads values typed back in. It supports backspace, escape and error flagging.

---
 rtl/ascii2bin.sv | 106 ++++++++++
 tb/tb_ascii2bin.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii2bin.sv
// Hex-text parser: assembles typed ASCII hex digits into a binary word and
// publishes it on Enter through a valid/ready port. Supports backspace and escape.
module ascii2bin #(
   parameter  int NBYTES = 2,
   localparam int NDIG   = 2 * NBYTES,
   localparam int W      = 8 * NBYTES,
   localparam int CW     = $clog2(NDIG + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic [W-1:0]  o_data,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [CW-1:0] digit_cnt,
   output logic          err
);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t        state;
   logic [W-1:0]  acc;
   logic [CW-1:0] cnt;
   logic          is_dig;
   logic [3:0]    nib;

   assign rx_ready  = (state == COLLECT);
   assign digit_cnt = cnt;

   // Upper and lower case letters map to the same nibble
   always_comb begin
      is_dig = 1'b0;
      nib    = 4'd0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         is_dig = 1'b1;
         nib    = 4'(rx_data - 8'h30);
      end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
         is_dig = 1'b1;
         nib    = 4'(rx_data - 8'h37);
      end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
         is_dig = 1'b1;
         nib    = 4'(rx_data - 8'h57);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= COLLECT;
         acc     <= '0;
         cnt     <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         err     <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            COLLECT: begin
               // rx_ready is high in this state, so rx_valid alone means consumed
               if (rx_valid) begin
                  if (is_dig) begin
                     if (cnt < CW'(NDIG)) begin
                        acc <= {acc[W-5:0], nib};
                        cnt <= cnt + CW'(1);
                     end else begin
                        err <= 1'b1;
                     end
                  end else begin
                     case (rx_data)
                        8'h08: begin
                           if (cnt != '0) begin
                              acc <= acc >> 4;
                              cnt <= cnt - CW'(1);
                           end
                        end
                        8'h1B: begin
                           acc <= '0;
                           cnt <= '0;
                        end
                        8'h0D: begin
                           if (cnt != '0) begin
                              o_data  <= acc;
                              o_valid <= 1'b1;
                              acc     <= '0;
                              cnt     <= '0;
                              state   <= HOLD;
                           end
                        end
                        default: err <= 1'b1;
                     endcase
                  end
               end
            end
            HOLD: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  state   <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_ascii2bin.sv
// Bench for ascii2bin: scoreboard of expected words pushed on Enter and
// popped on each output transfer; NBYTES=2 and NBYTES=1 instances.
module tb_ascii2bin;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [2:0]  digit_cnt;
   logic        err;

   logic [7:0]  rx_data1 = 8'h00;
   logic        rx_valid1 = 1'b0;
   logic        rx_ready1;
   logic [7:0]  o_data1;
   logic        o_valid1;
   logic        o_ready1 = 1'b1;
   logic [1:0]  digit_cnt1;
   logic        err1;

   int n_tests = 0;
   int n_fail  = 0;
   int beats = 0, beats1 = 0, valid_cycles = 0, err_cnt = 0;
   logic [15:0] q[$];
   logic [7:0]  q1[$];

   always #5 clk = ~clk;

   ascii2bin #(.NBYTES(2)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .digit_cnt(digit_cnt), .err(err)
   );

   ascii2bin #(.NBYTES(1)) dut1 (
      .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
      .o_data(o_data1), .o_valid(o_valid1), .o_ready(o_ready1), .digit_cnt(digit_cnt1), .err(err1)
   );

   // Scoreboard monitors: compare every output transfer against the queued word
   always @(negedge clk) begin
      if (!rst) begin
         if (err) err_cnt++;
         if (o_valid) valid_cycles++;
         if (o_valid && o_ready) begin
            beats++;
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got o_data=%h, expected no output", o_data);
            end else begin
               logic [15:0] exp_w;
               exp_w = q.pop_front();
               if (o_data !== exp_w) begin
                  n_fail++;
                  $display("FAIL sb_word: got o_data=%h, expected %h", o_data, exp_w);
               end
            end
         end
         if (o_valid1 && o_ready1) begin
            beats1++;
            n_tests++;
            if (q1.size() == 0) begin
               n_fail++;
               $display("FAIL sb1_unexpected: got o_data=%h, expected no output", o_data1);
            end else begin
               logic [7:0] exp_b;
               exp_b = q1.pop_front();
               if (o_data1 !== exp_b) begin
                  n_fail++;
                  $display("FAIL sb1_word: got o_data=%h, expected %h", o_data1, exp_b);
               end
            end
         end
      end
   end

   // Offers c and returns 1ns after the edge that consumes it
   task automatic send(input logic [7:0] c);
      bit done = 0;
      @(negedge clk);
      rx_data  = c;
      rx_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (rx_ready) begin
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      #1 rx_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: char %h not consumed, expected rx_ready within 50 cycles", c);
      end
   endtask

   task automatic send1(input logic [7:0] c);
      bit done = 0;
      @(negedge clk);
      rx_data1  = c;
      rx_valid1 = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (rx_ready1) begin
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      #1 rx_valid1 = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send1_timeout: char %h not consumed", c);
      end
   endtask

   task automatic test_reset;
      #3;
      n_tests++;
      if (rx_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 16'h0 || digit_cnt !== 3'd0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%0d err=%b, expected 1 0 0000 0 0",
                  rx_ready, o_valid, o_data, digit_cnt, err);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_full_word;
      logic [7:0] s[4] = '{"1", "a", "F", "3"};
      int b0, v0, e0;
      o_ready = 1'b1;
      b0 = beats; v0 = valid_cycles; e0 = err_cnt;
      for (int i = 0; i < 4; i++) begin
         send(s[i]);
         n_tests++;
         if (digit_cnt !== 3'(i + 1)) begin
            n_fail++;
            $display("FAIL full_cnt: digit_cnt=%0d, expected %0d", digit_cnt, i + 1);
         end
      end
      q.push_back(16'h1AF3);
      send(8'h0D);
      repeat (4) @(negedge clk);
      n_tests++;
      if (beats - b0 != 1 || valid_cycles - v0 != 1 || err_cnt != e0) begin
         n_fail++;
         $display("FAIL full_beat: beats=%0d valid_cycles=%0d errs=%0d, expected 1 1 0",
                  beats - b0, valid_cycles - v0, err_cnt - e0);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] s[4] = '{"1", "2", "3", "4"};
      for (int i = 0; i < 4; i++) send(s[i]);
      send("5");
      n_tests++;
      if (err !== 1'b1 || digit_cnt !== 3'd4) begin
         n_fail++;
         $display("FAIL overflow: err=%b cnt=%0d, expected 1 4", err, digit_cnt);
      end
      send(8'h08);
      n_tests++;
      if (digit_cnt !== 3'd3 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL backspace: cnt=%0d err=%b, expected 3 0", digit_cnt, err);
      end
      send("9");
      q.push_back(16'h1239);
      send(8'h0D);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure;
      int b0;
      o_ready = 1'b0;
      send("7");
      send("F");
      q.push_back(16'h007F);
      send(8'h0D);
      b0 = beats;
      rx_data  = "1";
      rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (o_valid !== 1'b1 || o_data !== 16'h007F || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: vld=%b data=%h rdy=%b, expected 1 007f 0", o_valid, o_data, rx_ready);
         end
      end
      rx_valid = 1'b0;
      n_tests++;
      if (digit_cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL bp_noconsume: cnt=%0d, expected 0", digit_cnt);
      end
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (o_valid !== 1'b0 || rx_ready !== 1'b1 || beats - b0 != 1) begin
         n_fail++;
         $display("FAIL bp_release: vld=%b rdy=%b beats=%0d, expected 0 1 1", o_valid, rx_ready, beats - b0);
      end
   endtask

   task automatic test_illegal;
      logic [7:0] s[3] = '{"G", 8'h20, "z"};
      int v0;
      o_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(s[i]);
         n_tests++;
         if (err !== 1'b1 || digit_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL illegal_err: char=%h err=%b cnt=%0d, expected 1 0", s[i], err, digit_cnt);
         end
         @(posedge clk);
         #1;
         n_tests++;
         if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: err=%b one cycle later, expected 0", err);
         end
      end
      v0 = valid_cycles;
      send(8'h0D);
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_enter_err: err=%b, expected 0", err);
      end
      send("A");
      send(8'h1B);
      n_tests++;
      if (digit_cnt !== 3'd0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL escape: cnt=%0d err=%b, expected 0 0", digit_cnt, err);
      end
      send(8'h0D);
      repeat (3) @(negedge clk);
      n_tests++;
      if (valid_cycles != v0) begin
         n_fail++;
         $display("FAIL no_output: valid_cycles=%0d, expected 0", valid_cycles - v0);
      end
   endtask

   task automatic test_reset_hold;
      o_ready = 1'b0;
      send("5");
      send("5");
      send(8'h0D);
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== 16'h0055) begin
         n_fail++;
         $display("FAIL hold_pre: vld=%b data=%h, expected 1 0055", o_valid, o_data);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (o_valid !== 1'b0 || o_data !== 16'h0 || rx_ready !== 1'b1 || digit_cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL hold_reset: vld=%b data=%h rdy=%b cnt=%0d, expected 0 0000 1 0",
                  o_valid, o_data, rx_ready, digit_cnt);
      end
      rst = 1'b0;
      o_ready = 1'b1;
      send("3");
      q.push_back(16'h0003);
      send(8'h0D);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_sweep;
      send1("A");
      send1("B");
      send1("C");
      n_tests++;
      if (err1 !== 1'b1 || digit_cnt1 !== 2'd2) begin
         n_fail++;
         $display("FAIL sweep_overflow: err=%b cnt=%0d, expected 1 2", err1, digit_cnt1);
      end
      q1.push_back(8'hAB);
      send1(8'h0D);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_full_word;
      test_overflow;
      test_backpressure;
      test_illegal;
      test_reset_hold;
      test_sweep;
      n_tests++;
      if (q.size() != 0 || q1.size() != 0 || beats != 4 || beats1 != 1) begin
         n_fail++;
         $display("FAIL sb_drain: left=%0d/%0d beats=%0d/%0d, expected 0/0 4/1",
                  q.size(), q1.size(), beats, beats1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
